// File: rtl/hyperbus_rbus_flat_arb.sv
// Round-robin arbiter folding NumPorts flattened regbus ports onto one
// flattened regbus master port. A stall timeout answers a hung access with
// an error so a dead downstream clock domain cannot lock a requester.
//
// state | meaning
// IDLE  | no access in flight; choose the next valid port from rr_q
// BUSY  | port gnt_q forwarded downstream; waiting for ready/timeout/withdraw
module hyperbus_rbus_flat_arb #(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned RegAddrWidth  = 32,
  parameter int unsigned RegDataWidth  = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic                                      clk_sys_i,
  input  logic                                      rst_sys_ni,
  input  logic [NumPorts-1:0][RegAddrWidth-1:0]     rbus_req_addr_i,
  input  logic [NumPorts-1:0]                       rbus_req_write_i,
  input  logic [NumPorts-1:0][RegDataWidth-1:0]     rbus_req_wdata_i,
  input  logic [NumPorts-1:0][RegDataWidth/8-1:0]   rbus_req_wstrb_i,
  input  logic [NumPorts-1:0]                       rbus_req_valid_i,
  output logic [NumPorts-1:0][RegDataWidth-1:0]     rbus_rsp_rdata_o,
  output logic [NumPorts-1:0]                       rbus_rsp_ready_o,
  output logic [NumPorts-1:0]                       rbus_rsp_error_o,
  output logic [RegAddrWidth-1:0]                   rbus_mst_req_addr_o,
  output logic                                      rbus_mst_req_write_o,
  output logic [RegDataWidth-1:0]                   rbus_mst_req_wdata_o,
  output logic [RegDataWidth/8-1:0]                 rbus_mst_req_wstrb_o,
  output logic                                      rbus_mst_req_valid_o,
  input  logic [RegDataWidth-1:0]                   rbus_mst_rsp_rdata_i,
  input  logic                                      rbus_mst_rsp_ready_i,
  input  logic                                      rbus_mst_rsp_error_i,
  output logic                                      timeout_o,
  output logic                                      busy_o
);

  localparam int unsigned IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  // A disabled timeout yields a zero-width counter; keep one bit so the
  // register stays legal (it is never compared in that case).
  localparam int unsigned CntW    = (CntWidth > 0) ? CntWidth : 1;
  localparam int unsigned CntLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     gnt_q, gnt_d, rr_q, rr_d;
  logic [IdxW-1:0]     pick, cand, gnt_inc;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                any_vld, gnt_vld, to_fire, busy;
  int unsigned         idx;

  assign busy    = (state_q == BUSY);
  assign gnt_vld = rbus_req_valid_i[gnt_q];
  assign gnt_inc = (gnt_q == IdxW'(NumPorts - 1)) ? '0 : gnt_q + 1'b1;

  // First valid port scanning upward from rr_q with wrap-around.
  always_comb begin
    pick    = '0;
    cand    = '0;
    idx     = 0;
    any_vld = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NumPorts) idx = idx - NumPorts;
      cand = IdxW'(idx);
      if (!any_vld && rbus_req_valid_i[cand]) begin
        any_vld = 1'b1;
        pick    = cand;
      end
    end
  end

  // Next-state, grant, round-robin pointer and stall counter.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    to_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_vld) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!gnt_vld) begin
          // Requester withdrew: drop the access silently.
          state_d = IDLE;
          rr_d    = gnt_inc;
        end else if (rbus_mst_rsp_ready_i) begin
          // A real response beats a timeout landing in the same cycle.
          state_d = IDLE;
          rr_d    = gnt_inc;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntW'(CntLast))) begin
          to_fire = 1'b1;
          state_d = IDLE;
          rr_d    = gnt_inc;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (NumPorts == 1) begin
      gnt_d = '0;
      rr_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Downstream request: granted port's fields, only while BUSY.
  always_comb begin
    rbus_mst_req_addr_o  = '0;
    rbus_mst_req_write_o = 1'b0;
    rbus_mst_req_wdata_o = '0;
    rbus_mst_req_wstrb_o = '0;
    rbus_mst_req_valid_o = 1'b0;
    if (busy) begin
      rbus_mst_req_addr_o  = rbus_req_addr_i[gnt_q];
      rbus_mst_req_write_o = rbus_req_write_i[gnt_q];
      rbus_mst_req_wdata_o = rbus_req_wdata_i[gnt_q];
      rbus_mst_req_wstrb_o = rbus_req_wstrb_i[gnt_q];
      rbus_mst_req_valid_o = gnt_vld && !to_fire;
    end
  end

  // Upstream responses: only the granted port ever sees a completion.
  always_comb begin
    rbus_rsp_rdata_o = '0;
    rbus_rsp_ready_o = '0;
    rbus_rsp_error_o = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (busy && (gnt_q == IdxW'(i))) begin
        if (to_fire) begin
          rbus_rsp_ready_o[i] = 1'b1;
          rbus_rsp_error_o[i] = 1'b1;
        end else if (gnt_vld && rbus_mst_rsp_ready_i) begin
          rbus_rsp_ready_o[i] = 1'b1;
          rbus_rsp_error_o[i] = rbus_mst_rsp_error_i;
          rbus_rsp_rdata_o[i] = rbus_mst_rsp_rdata_i;
        end
      end
    end
  end

  assign timeout_o = to_fire;
  assign busy_o    = busy;

endmodule

// File: tb/tb_hyperbus_rbus_flat_arb.sv
// Directed per-cycle vector bench for hyperbus_rbus_flat_arb (4 ports,
// 8-cycle timeout) plus a hand-written reset-mid-transaction sequence.
module tb_hyperbus_rbus_flat_arb;

  localparam int NP = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NP-1:0][31:0]   req_addr;
  logic [NP-1:0]         req_write;
  logic [NP-1:0][31:0]   req_wdata;
  logic [NP-1:0][3:0]    req_wstrb;
  logic [NP-1:0]         req_valid;
  logic [NP-1:0][31:0]   rsp_rdata;
  logic [NP-1:0]         rsp_ready;
  logic [NP-1:0]         rsp_error;
  logic [31:0]           mst_addr;
  logic                  mst_write;
  logic [31:0]           mst_wdata;
  logic [3:0]            mst_wstrb;
  logic                  mst_valid;
  logic [31:0]           mst_rdata;
  logic                  mst_ready;
  logic                  mst_error;
  logic                  timeout;
  logic                  busy;

  always #5 clk = ~clk;

  hyperbus_rbus_flat_arb #(
    .NumPorts(NP), .RegAddrWidth(32), .RegDataWidth(32), .TimeoutCycles(8)
  ) dut (
    .clk_sys_i            (clk),
    .rst_sys_ni           (rst_n),
    .rbus_req_addr_i      (req_addr),
    .rbus_req_write_i     (req_write),
    .rbus_req_wdata_i     (req_wdata),
    .rbus_req_wstrb_i     (req_wstrb),
    .rbus_req_valid_i     (req_valid),
    .rbus_rsp_rdata_o     (rsp_rdata),
    .rbus_rsp_ready_o     (rsp_ready),
    .rbus_rsp_error_o     (rsp_error),
    .rbus_mst_req_addr_o  (mst_addr),
    .rbus_mst_req_write_o (mst_write),
    .rbus_mst_req_wdata_o (mst_wdata),
    .rbus_mst_req_wstrb_o (mst_wstrb),
    .rbus_mst_req_valid_o (mst_valid),
    .rbus_mst_rsp_rdata_i (mst_rdata),
    .rbus_mst_rsp_ready_i (mst_ready),
    .rbus_mst_rsp_error_i (mst_error),
    .timeout_o            (timeout),
    .busy_o               (busy)
  );

  typedef struct {
    logic [3:0]  vld;
    logic        mrdy;
    logic        merr;
    logic [31:0] mrdata;
    logic        ebusy;
    logic        emv;
    int          egnt;
    logic [3:0]  erdy;
    logic [3:0]  eerr;
    logic        eto;
    logic [31:0] erdata;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_row = 0;

  // Static per-port request fields.
  logic [31:0] p_addr  [NP] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0010, 32'h0000_010C};
  logic [31:0] p_wdata [NP] = '{32'h0101_0101, 32'h0202_0202, 32'hA5A5_A5A5, 32'h0404_0404};
  logic        p_write [NP] = '{1'b0, 1'b0, 1'b1, 1'b0};

  function automatic vec_t mk(logic [3:0] vld, logic mrdy, logic merr, logic [31:0] mrdata,
                              logic ebusy, logic emv, int egnt, logic [3:0] erdy,
                              logic [3:0] eerr, logic eto, logic [31:0] erdata);
    vec_t v;
    v.vld = vld; v.mrdy = mrdy; v.merr = merr; v.mrdata = mrdata;
    v.ebusy = ebusy; v.emv = emv; v.egnt = egnt; v.erdy = erdy;
    v.eerr = eerr; v.eto = eto; v.erdata = erdata;
    return v;
  endfunction

  function automatic vec_t idle(logic [3:0] vld);
    return mk(vld, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 4'b0, 4'b0, 1'b0, 32'h0);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d actual=%0h expected=%0h", name, cur_row, act, exp);
    end
  endtask

  task automatic check_row(vec_t v);
    logic [NP-1:0][31:0] exp_rdata;
    for (int p = 0; p < NP; p++) exp_rdata[p] = v.erdy[p] ? v.erdata : 32'h0;
    chk("busy", 128'(busy), 128'(v.ebusy));
    chk("mst_valid", 128'(mst_valid), 128'(v.emv));
    chk("timeout", 128'(timeout), 128'(v.eto));
    chk("rsp_ready", 128'(rsp_ready), 128'(v.erdy));
    chk("rsp_error", 128'(rsp_error), 128'(v.eerr));
    chk("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
    if (v.emv) begin
      chk("mst_addr", 128'(mst_addr), 128'(p_addr[v.egnt]));
      chk("mst_wdata", 128'(mst_wdata), 128'(p_wdata[v.egnt]));
      chk("mst_write", 128'(mst_write), 128'(p_write[v.egnt]));
      chk("mst_wstrb", 128'(mst_wstrb), 128'(4'hF));
    end
  endtask

  initial begin
    // Single access from port 2, then port 3 wins over 0 (rr_q == 3).
    tbl.push_back(idle(4'b0100));
    tbl.push_back(mk(4'b0100, 1, 0, 32'h1111_1111, 1, 1, 2, 4'b0100, 4'b0, 0, 32'h1111_1111));
    tbl.push_back(idle(4'b1001));
    tbl.push_back(mk(4'b1001, 1, 0, 32'h3333_3333, 1, 1, 3, 4'b1000, 4'b0, 0, 32'h3333_3333));
    // Fairness: all ports valid, order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      tbl.push_back(idle(4'b1111));
      tbl.push_back(mk(4'b1111, 1, 0, 32'hC0DE_0000 + 32'(g), 1, 1, g, 4'(1 << g), 4'b0, 0,
                       32'hC0DE_0000 + 32'(g)));
    end
    tbl.push_back(idle(4'b0000));
    // Wait states: port 0, 5 stall cycles then DEADBEEF.
    tbl.push_back(idle(4'b0001));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(4'b0001, 0, 0, 32'h0BAD_0BAD, 1, 1, 0, 4'b0, 4'b0, 0, 32'h0));
    tbl.push_back(mk(4'b0001, 1, 0, 32'hDEAD_BEEF, 1, 1, 0, 4'b0001, 4'b0, 0, 32'hDEAD_BEEF));
    tbl.push_back(idle(4'b0000));
    // Timeout: port 1, downstream never ready; error in BUSY cycle 8.
    tbl.push_back(idle(4'b0010));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(4'b0010, 0, 0, 32'hFFFF_FFFF, 1, 1, 1, 4'b0, 4'b0, 0, 32'h0));
    tbl.push_back(mk(4'b0010, 0, 0, 32'hFFFF_FFFF, 1, 0, 1, 4'b0010, 4'b0010, 1, 32'h0));
    tbl.push_back(idle(4'b0000));
    // Race: port 3, ready arrives in BUSY cycle 8 -> normal response.
    tbl.push_back(idle(4'b1000));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(4'b1000, 0, 0, 32'h7777_7777, 1, 1, 3, 4'b0, 4'b0, 0, 32'h0));
    tbl.push_back(mk(4'b1000, 1, 0, 32'h1234_5678, 1, 1, 3, 4'b1000, 4'b0, 0, 32'h1234_5678));
    tbl.push_back(idle(4'b0000));
    // Downstream error passes through on port 1.
    tbl.push_back(idle(4'b0010));
    tbl.push_back(mk(4'b0010, 1, 1, 32'hCAFE_F00D, 1, 1, 1, 4'b0010, 4'b0010, 0, 32'hCAFE_F00D));
    tbl.push_back(idle(4'b0000));
    // Withdraw: port 0 drops valid while BUSY; rr still advances to 1.
    tbl.push_back(idle(4'b0001));
    tbl.push_back(mk(4'b0001, 0, 0, 32'h0, 1, 1, 0, 4'b0, 4'b0, 0, 32'h0));
    tbl.push_back(mk(4'b0000, 0, 0, 32'h0, 1, 0, 0, 4'b0, 4'b0, 0, 32'h0));
    tbl.push_back(idle(4'b0000));
    tbl.push_back(idle(4'b0011));
    tbl.push_back(mk(4'b0011, 1, 0, 32'h5555_AAAA, 1, 1, 1, 4'b0010, 4'b0, 0, 32'h5555_AAAA));
    tbl.push_back(idle(4'b0000));

    for (int p = 0; p < NP; p++) begin
      req_addr[p]  = p_addr[p];
      req_wdata[p] = p_wdata[p];
      req_write[p] = p_write[p];
      req_wstrb[p] = 4'hF;
    end
    req_valid = '0;
    mst_ready = 1'b0;
    mst_error = 1'b0;
    mst_rdata = '0;
    rst_n     = 1'b0;

    #1;
    cur_row = -1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_mst_valid", 128'(mst_valid), 128'(0));
    chk("rst_mst_addr", 128'(mst_addr), 128'(0));
    chk("rst_rsp_ready", 128'(rsp_ready), 128'(0));
    chk("rst_timeout", 128'(timeout), 128'(0));

    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      cur_row   = r;
      req_valid = tbl[r].vld;
      mst_ready = tbl[r].mrdy;
      mst_error = tbl[r].merr;
      mst_rdata = tbl[r].mrdata;
      @(negedge clk);
      check_row(tbl[r]);
      @(posedge clk); #1;
    end

    // Reset in BUSY cycle 3 of a port-0 access (rr_q is 2 here).
    cur_row   = 1000;
    req_valid = 4'b0001;
    mst_ready = 1'b0;
    mst_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_mst_valid", 128'(mst_valid), 128'(0));
    chk("mid_rst_mst_addr", 128'(mst_addr), 128'(0));
    chk("mid_rst_rsp_ready", 128'(rsp_ready), 128'(0));
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Ports 1 and 3 request; a reset rr_q must grant port 1 first.
    req_valid = 4'b1010;
    @(posedge clk); #1;
    mst_ready = 1'b1;
    mst_rdata = 32'h0F0F_0F0F;
    @(negedge clk);
    chk("post_rst_busy", 128'(busy), 128'(1));
    chk("post_rst_mst_addr", 128'(mst_addr), 128'(p_addr[1]));
    chk("post_rst_rsp_ready", 128'(rsp_ready), 128'(4'b0010));
    chk("post_rst_rsp_rdata", 128'(rsp_rdata), {32'h0, 32'h0, 32'h0F0F_0F0F, 32'h0});
    @(posedge clk); #1;
    req_valid = '0;
    mst_ready = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
